mdio_phy_responder: RTL
=======================

# mdio_phy_responder

Behavioural-synthesizable Clause-22 MDIO PHY management responder: the far end of the MCU's MDC/MDIO master. It oversamples MDC/MDIO on the system clock, decodes read/write frames addressed to its PHY address, and serves a 32×16 register bank. It drives MDIO only during read turnaround/data. The simulation top instantiates it on the MDC/MDIO pins; it is also usable as an FPGA-side PHY stub.

## Interface
- PHY_ADDR, 5'd1: PHY address this responder answers to.
- PRE_LEN, 32: consecutive preamble ones required before ST (legal range 1..32).
- PHY_ID, 32'h0141_0CC2: reset/fixed value of reg2 (bits 31:16) and reg3 (bits 15:0).
- STATUS_VAL, 16'h786D: fixed read value of reg1.
- clk  in  1  system clock; MDC period must be ≥ 8 clk periods.
- rst  in  1  synchronous, active-high reset.
- mdc  in  1  management clock from MCU (asynchronous to clk).
- mdio_i  in  1  MDIO pin input (asynchronous).
- mdio_o  out  1  MDIO drive value; reset 0.
- mdio_oe  out  1  MDIO output enable, 1 = drive; reset 0.
- wr_valid  out  1  one-clk pulse on completed write to this PHY; reset 0.
- wr_addr  out  5  register address of last write; reset 0.
- wr_data  out  16  data of last write; reset 0.
- frame_err  out  1  one-clk pulse on aborted frame (bad ST/OP/TA); reset 0.

## Operation
- mdc and mdio_i pass through 2-flop synchronizers; an MDC rise is detected when synced mdc = 1 and previous = 0. All decoding happens on detected MDC rises ("rise"), sampling synced MDIO.
- Frame bit index n counts rises after preamble: ST n=0..1, OP 2..3, PHYAD 4..8, REGAD 9..13, TA 14..15, DATA 16..31, MSB first.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA.
- IDLE: preamble counter increments on each sampled 1 (saturates at PRE_LEN) and clears on a sampled 0 while below PRE_LEN. A 0 sampled with counter = PRE_LEN -> ST.
- ST: next bit must be 1, else frame_err, -> IDLE.
- OP: 2'b10 = read, 2'b01 = write; 00/11 -> frame_err, IDLE.
- PHYAD ≠ PHY_ADDR: -> IDLE silently, no drive, no error. The preamble requirement prevents resync on data bits.
- Read: at the rise sampling n=14, assert mdio_oe=1, mdio_o=0 (TA2). At rises n=15..30, drive reg[REGAD] bits 15..0. At rise n=31, mdio_oe=0, -> IDLE.
- Write: TA n=15 must sample 0, else frame_err, -> IDLE, no write. Shift DATA. At rise n=31, update reg (unless read-only), set wr_addr/wr_data, pulse wr_valid, -> IDLE. Read-only targets still pulse wr_valid.
- Register bank: reg1 = STATUS_VAL, read-only. reg2/reg3 = PHY_ID halves, read-only. All other regs RW, reset 0.
- Register content is latched for reads at the rise sampling n=13, so a concurrent write cannot tear a read.
- Preamble counter resets to 0 on every return to IDLE.

## Timing
- MDC rise at pin -> internal rise detect: 2–3 clk (synchronizer). Outputs update on the clk edge after the detect. Total pin-to-output latency is 3–4 clk; the master sees the new bit well before its next rise when the MDC period is ≥ 8 clk.
- wr_valid and frame_err are exactly 1 clk wide.
- rst mid-frame: next clk gives state IDLE, mdio_oe=0, mdio_o=0, pulses 0, bank at reset values, synchronizer flops cleared.
- An MDC fall has no effect. Glitches shorter than 1 clk are not required to be filtered.

## Structure
- Package mdio_pkg: state enum, OP_READ=2'b10, OP_WRITE=2'b01, field bit-index constants (ST_END=1, OP_END=3, PHYAD_END=8, REGAD_END=13, TA_END=15, DATA_END=31).
- Sub-module mdio_sync_edge: 2-flop sync of mdc/mdio_i with rise pulse output.
- The bank is a flop array inside the top module.

## Test plan
- Reset, then a 32-one preamble and a read of reg2 at PHYAD 1 -> TA2 driven 0, DATA = 16'h0141, oe drops after bit 0.
- Write 16'hA5C3 to reg5, then read reg5 -> wr_valid pulse with wr_addr=5, wr_data=A5C3; read returns A5C3.
- Write 16'h0000 to reg1, then read -> wr_valid pulses; read returns 16'h786D.
- Read addressed to PHYAD 3 -> mdio_oe stays 0 through the whole frame, no pulses.
- Preamble of 31 ones then ST -> ignored. OP=2'b11 after a valid preamble -> frame_err pulse. Write with TA2=1 -> frame_err, bank unchanged.
- rst asserted at read DATA bit 8 -> mdio_oe=0 next clk, reg5 returns to 0, and a following full read frame works.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared types and frame-field constants for the Clause-22 MDIO PHY responder.
package mdio_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ST    = 3'd1,
      S_OP    = 3'd2,
      S_PHYAD = 3'd3,
      S_REGAD = 3'd4,
      S_TA    = 3'd5,
      S_RDATA = 3'd6,
      S_WDATA = 3'd7
   } mdio_state_e;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;

   // Last bit index n of each frame field, counted in MDC rises after the preamble
   localparam logic [4:0] ST_END    = 5'd1;
   localparam logic [4:0] OP_END    = 5'd3;
   localparam logic [4:0] PHYAD_END = 5'd8;
   localparam logic [4:0] REGAD_END = 5'd13;
   localparam logic [4:0] TA_END    = 5'd15;
   localparam logic [4:0] DATA_END  = 5'd31;
   localparam logic [4:0] TA_FIRST  = REGAD_END + 5'd1;

   function automatic logic is_read_only(input logic [4:0] addr);
      return (addr == 5'd1) || (addr == 5'd2) || (addr == 5'd3);
   endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizers for MDC/MDIO plus an MDC rising-edge pulse in the clk domain.
module mdio_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic mdc,
   input  logic mdio_i,
   output logic mdc_rise,
   output logic mdio_s
);

   // mdc_sh[1] is the synchronized level, mdc_sh[2] its previous value
   logic [2:0] mdc_sh_q, mdc_sh_d;
   logic [1:0] mdio_sh_q, mdio_sh_d;

   always_comb begin
      mdc_sh_d  = {mdc_sh_q[1:0], mdc};
      mdio_sh_d = {mdio_sh_q[0], mdio_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mdc_sh_q  <= '0;
         mdio_sh_q <= '0;
      end else begin
         mdc_sh_q  <= mdc_sh_d;
         mdio_sh_q <= mdio_sh_d;
      end
   end

   assign mdc_rise = mdc_sh_q[1] & ~mdc_sh_q[2];
   assign mdio_s   = mdio_sh_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: decodes frames on oversampled MDC rises and serves a 32x16 register bank.
module mdio_phy_responder
   import mdio_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR   = 5'd1,
   parameter int          PRE_LEN    = 32,
   parameter logic [31:0] PHY_ID     = 32'h0141_0CC2,
   parameter logic [15:0] STATUS_VAL = 16'h786D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   output logic        wr_valid,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_err
);

   localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

   logic rise, mdio_s;

   mdio_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .mdc      (mdc),
      .mdio_i   (mdio_i),
      .mdc_rise (rise),
      .mdio_s   (mdio_s)
   );

   mdio_state_e  state_q, state_d;
   logic [5:0]   pre_q, pre_d;
   logic [4:0]   cnt_q, cnt_d;
   logic         op_hi_q, op_hi_d;
   logic         op_rd_q, op_rd_d;
   logic [4:0]   addr_sh_q, addr_sh_d;
   logic [4:0]   regad_q, regad_d;
   logic [15:0]  data_sh_q, data_sh_d;
   logic         mdio_o_q, mdio_o_d;
   logic         mdio_oe_q, mdio_oe_d;
   logic         wr_valid_q, wr_valid_d;
   logic [4:0]   wr_addr_q, wr_addr_d;
   logic [15:0]  wr_data_q, wr_data_d;
   logic         frame_err_q, frame_err_d;
   logic [15:0]  bank_q [32];
   logic [15:0]  bank_d [32];

   logic [4:0]   addr_now;
   logic [15:0]  rd_word;

   assign addr_now = {addr_sh_q[3:0], mdio_s};

   // Read-only registers are served from parameters; their bank slots stay unused
   always_comb begin
      case (addr_now)
         5'd1:    rd_word = STATUS_VAL;
         5'd2:    rd_word = PHY_ID[31:16];
         5'd3:    rd_word = PHY_ID[15:0];
         default: rd_word = bank_q[addr_now];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pre_d       = pre_q;
      cnt_d       = cnt_q;
      op_hi_d     = op_hi_q;
      op_rd_d     = op_rd_q;
      addr_sh_d   = addr_sh_q;
      regad_d     = regad_q;
      data_sh_d   = data_sh_q;
      mdio_o_d    = mdio_o_q;
      mdio_oe_d   = mdio_oe_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      frame_err_d = 1'b0;
      bank_d      = bank_q;

      if (rise) begin
         cnt_d = cnt_q + 5'd1;
         case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (mdio_s) begin
                  if (pre_q != PRE_MAX) pre_d = pre_q + 6'd1;
               end else if (pre_q == PRE_MAX) begin
                  // This 0 is ST bit n=0; counter cleared here so every IDLE return starts fresh
                  state_d = S_ST;
                  cnt_d   = ST_END;
                  pre_d   = '0;
               end else begin
                  pre_d = '0;
               end
            end
            S_ST: begin
               if (!mdio_s) begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_OP;
               end
            end
            S_OP: begin
               if (cnt_q != OP_END) begin
                  op_hi_d = mdio_s;
               end else if ({op_hi_q, mdio_s} == OP_READ) begin
                  op_rd_d = 1'b1;
                  state_d = S_PHYAD;
               end else if ({op_hi_q, mdio_s} == OP_WRITE) begin
                  op_rd_d = 1'b0;
                  state_d = S_PHYAD;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end
            S_PHYAD: begin
               addr_sh_d = addr_now;
               if (cnt_q == PHYAD_END) state_d = (addr_now == PHY_ADDR) ? S_REGAD : S_IDLE;
            end
            S_REGAD: begin
               addr_sh_d = addr_now;
               if (cnt_q == REGAD_END) begin
                  // Snapshot read data now so a later write cannot tear it
                  regad_d   = addr_now;
                  data_sh_d = rd_word;
                  state_d   = S_TA;
               end
            end
            S_TA: begin
               if (cnt_q == TA_FIRST) begin
                  if (op_rd_q) begin
                     mdio_oe_d = 1'b1;
                     mdio_o_d  = 1'b0;
                  end
               end else if (op_rd_q) begin
                  mdio_o_d  = data_sh_q[15];
                  data_sh_d = {data_sh_q[14:0], 1'b0};
                  state_d   = S_RDATA;
               end else if (mdio_s) begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_WDATA;
               end
            end
            S_RDATA: begin
               if (cnt_q == DATA_END) begin
                  mdio_oe_d = 1'b0;
                  mdio_o_d  = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  mdio_o_d  = data_sh_q[15];
                  data_sh_d = {data_sh_q[14:0], 1'b0};
               end
            end
            S_WDATA: begin
               data_sh_d = {data_sh_q[14:0], mdio_s};
               if (cnt_q == DATA_END) begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = regad_q;
                  wr_data_d  = data_sh_d;
                  if (!is_read_only(regad_q)) bank_d[regad_q] = data_sh_d;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pre_q       <= '0;
         cnt_q       <= '0;
         op_hi_q     <= 1'b0;
         op_rd_q     <= 1'b0;
         addr_sh_q   <= '0;
         regad_q     <= '0;
         data_sh_q   <= '0;
         mdio_o_q    <= 1'b0;
         mdio_oe_q   <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_err_q <= 1'b0;
         bank_q      <= '{default: '0};
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         cnt_q       <= cnt_d;
         op_hi_q     <= op_hi_d;
         op_rd_q     <= op_rd_d;
         addr_sh_q   <= addr_sh_d;
         regad_q     <= regad_d;
         data_sh_q   <= data_sh_d;
         mdio_o_q    <= mdio_o_d;
         mdio_oe_q   <= mdio_oe_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         frame_err_q <= frame_err_d;
         bank_q      <= bank_d;
      end
   end

   assign mdio_o    = mdio_o_q;
   assign mdio_oe   = mdio_oe_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign frame_err = frame_err_q;

endmodule
